// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks: glyph table constants,
// blanking codes and small types for nibbles and digit indices.
package seg7_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [1:0] digit_idx_t;

    // Segment order is {g,f,e,d,c,b,a}, active low.
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Active-low one-cold anode pattern for a digit position.
    function automatic logic [3:0] anode_sel(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex-to-7-segment decoder producing active-low segments.
// Shared by the scanned display and the single-digit counter display.
module hex7seg_dec
    import seg7_pkg::*;
(
    input  nibble_t    nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (nibble_i)
            4'h0: seg_o = GLYPH_0;
            4'h1: seg_o = GLYPH_1;
            4'h2: seg_o = GLYPH_2;
            4'h3: seg_o = GLYPH_3;
            4'h4: seg_o = GLYPH_4;
            4'h5: seg_o = GLYPH_5;
            4'h6: seg_o = GLYPH_6;
            4'h7: seg_o = GLYPH_7;
            4'h8: seg_o = GLYPH_8;
            4'h9: seg_o = GLYPH_9;
            4'hA: seg_o = GLYPH_A;
            4'hB: seg_o = GLYPH_B;
            4'hC: seg_o = GLYPH_C;
            4'hD: seg_o = GLYPH_D;
            4'hE: seg_o = GLYPH_E;
            4'hF: seg_o = GLYPH_F;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_mux4.sv
// Four-digit time-multiplexed 7-segment driver with per-slot anti-ghosting
// blank, once-per-frame input snapshot, leading-zero blanking and digit enables.
module seg7_scan_mux4
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 2000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    input  logic        blank_lz,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [3:0]  AN,
    output logic        frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } slot_state_t;

    logic [CW-1:0] slotCnt_q, slotCnt_d;
    digit_idx_t    digitIdx_q, digitIdx_d;
    logic [15:0]   valueSnap_q, valueSnap_d;
    logic [3:0]    dpSnap_q, dpSnap_d;
    logic [3:0]    enSnap_q, enSnap_d;
    logic          lzSnap_q, lzSnap_d;

    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frameTick_q, frameTick_d;

    slot_state_t   slotState;
    logic          frameStart;
    logic          zeroAbove;
    logic          suppressed;
    nibble_t       curNib;
    logic [6:0]    glyph;

    hex7seg_dec u_dec (
        .nibble_i (curNib),
        .seg_o    (glyph)
    );

    // Outputs are decoded from the snapshot as it will be after this edge, so
    // the digit-0 slot already uses the freshly captured frame.
    always_comb begin
        frameStart  = (slotCnt_q == '0) && (digitIdx_q == 2'd0);
        frameTick_d = frameStart;

        valueSnap_d = frameStart ? value    : valueSnap_q;
        dpSnap_d    = frameStart ? dp_in    : dpSnap_q;
        enSnap_d    = frameStart ? digit_en : enSnap_q;
        lzSnap_d    = frameStart ? blank_lz : lzSnap_q;

        slotCnt_d  = slotCnt_q + CW'(1);
        digitIdx_d = digitIdx_q;
        if (slotCnt_q == SLOT_LAST) begin
            slotCnt_d  = '0;
            digitIdx_d = digitIdx_q + 2'd1;
        end

        slotState = (slotCnt_q < BLANK_LIM) ? ST_BLANK : ST_SHOW;

        curNib = valueSnap_d[{digitIdx_q, 2'b00} +: 4];

        zeroAbove = 1'b0;
        case (digitIdx_q)
            2'd0: zeroAbove = 1'b0;
            2'd1: zeroAbove = (valueSnap_d[15:4]  == 12'h000);
            2'd2: zeroAbove = (valueSnap_d[15:8]  == 8'h00);
            2'd3: zeroAbove = (valueSnap_d[15:12] == 4'h0);
            default: zeroAbove = 1'b0;
        endcase
        suppressed = !enSnap_d[digitIdx_q] || (lzSnap_d && zeroAbove);

        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (slotState == ST_SHOW && !suppressed) begin
            an_d  = anode_sel(digitIdx_q);
            seg_d = glyph;
            dp_d  = ~dpSnap_d[digitIdx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slotCnt_q   <= '0;
            digitIdx_q  <= 2'd0;
            valueSnap_q <= 16'h0000;
            dpSnap_q    <= 4'h0;
            enSnap_q    <= 4'h0;
            lzSnap_q    <= 1'b0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            frameTick_q <= 1'b0;
        end else begin
            slotCnt_q   <= slotCnt_d;
            digitIdx_q  <= digitIdx_d;
            valueSnap_q <= valueSnap_d;
            dpSnap_q    <= dpSnap_d;
            enSnap_q    <= enSnap_d;
            lzSnap_q    <= lzSnap_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            frameTick_q <= frameTick_d;
        end
    end

    assign AN         = an_q;
    assign SEG        = seg_q;
    assign DP         = dp_q;
    assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_seg7_scan_mux4.sv
// Directed self-checking bench for seg7_scan_mux4 with REFRESH_DIV=8 and
// BLANK_CYC=2, so one frame is 32 cycles and each slot starts with 2 blank cycles.
module tb_seg7_scan_mux4;

    localparam int RDIV  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * RDIV;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        blank_lz;
    logic [6:0]  SEG;
    logic        DP;
    logic [3:0]  AN;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    seg7_scan_mux4 #(.REFRESH_DIV(RDIV), .BLANK_CYC(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .blank_lz   (blank_lz),
        .SEG        (SEG),
        .DP         (DP),
        .AN         (AN),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {AN,SEG,DP} at cycle c of a frame (c=0 is the frame_tick cycle).
    // anV/segV/dpV hold hand-computed per-digit SHOW values, digit 0 in the low bits.
    function automatic logic [11:0] frameExp(input int c, input logic [15:0] anV,
                                             input logic [27:0] segV, input logic [3:0] dpV);
        int k;
        int s;
        k = c / RDIV;
        s = c % RDIV;
        if (s < BLANK) return {4'hF, 7'h7F, 1'b1};
        return {anV[k*4 +: 4], segV[k*7 +: 7], dpV[k]};
    endfunction

    // Advances at least one cycle, then waits (bounded) for the next frame_tick.
    task automatic waitTick(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < FRAME + 8);
        checks++;
        if (frame_tick !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s_tick_timeout got=%b exp=1", name, frame_tick);
        end
    endtask

    task automatic test_reset();
        logic [11:0] e;
        rst      = 1'b1;
        value    = 16'h0000;
        dp_in    = 4'h0;
        digit_en = 4'hF;
        blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({AN, SEG, DP, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_out got=%h_%h_%b_%b exp=f_7f_1_0", AN, SEG, DP, frame_tick);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int c = 0; c < FRAME; c++) begin
            e = frameExp(c, 16'h7BDE, {4{7'b1000000}}, 4'hF);
            checks++;
            if ({AN, SEG, DP} !== e) begin
                failures++;
                $display("[TB] FAIL reset_frame c=%0d got=%h exp=%h", c, {AN, SEG, DP}, e);
            end
            checks++;
            if (frame_tick !== 1'(c == 0)) begin
                failures++;
                $display("[TB] FAIL reset_tick c=%0d got=%b exp=%b", c, frame_tick, c == 0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_scan();
        logic [11:0] e;
        value = 16'h12AF;
        waitTick("scan");
        for (int c = 0; c < FRAME; c++) begin
            e = frameExp(c, 16'h7BDE, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'hF);
            checks++;
            if ({AN, SEG, DP} !== e) begin
                failures++;
                $display("[TB] FAIL scan_frame c=%0d got=%h exp=%h", c, {AN, SEG, DP}, e);
            end
            checks++;
            if (frame_tick !== 1'(c == 0)) begin
                failures++;
                $display("[TB] FAIL scan_tick c=%0d got=%b exp=%b", c, frame_tick, c == 0);
            end
            @(negedge clk);
        end
        checks++;
        if (frame_tick !== 1'b1) begin
            failures++;
            $display("[TB] FAIL scan_period got=%b exp=1", frame_tick);
        end
    endtask

    task automatic test_snapshot();
        logic [11:0] e;
        waitTick("snap");
        for (int c = 0; c < FRAME; c++) begin
            if (c == 20) value = 16'h3456;
            e = frameExp(c, 16'h7BDE, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'hF);
            checks++;
            if ({AN, SEG, DP} !== e) begin
                failures++;
                $display("[TB] FAIL snap_old c=%0d got=%h exp=%h", c, {AN, SEG, DP}, e);
            end
            @(negedge clk);
        end
        for (int c = 0; c < FRAME; c++) begin
            e = frameExp(c, 16'h7BDE, {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}, 4'hF);
            checks++;
            if ({AN, SEG, DP} !== e) begin
                failures++;
                $display("[TB] FAIL snap_new c=%0d got=%h exp=%h", c, {AN, SEG, DP}, e);
            end
            checks++;
            if (frame_tick !== 1'(c == 0)) begin
                failures++;
                $display("[TB] FAIL snap_tick c=%0d got=%b exp=%b", c, frame_tick, c == 0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_leading_zero();
        logic [11:0] e;
        blank_lz = 1'b1;
        value    = 16'h0050;
        waitTick("lz");
        for (int c = 0; c < FRAME; c++) begin
            e = frameExp(c, 16'hFFDE, {7'h7F, 7'h7F, 7'b0010010, 7'b1000000}, 4'hF);
            checks++;
            if ({AN, SEG, DP} !== e) begin
                failures++;
                $display("[TB] FAIL lz_0050 c=%0d got=%h exp=%h", c, {AN, SEG, DP}, e);
            end
            @(negedge clk);
        end
        value = 16'h0000;
        waitTick("lz0");
        for (int c = 0; c < FRAME; c++) begin
            e = frameExp(c, 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'hF);
            checks++;
            if ({AN, SEG, DP} !== e) begin
                failures++;
                $display("[TB] FAIL lz_0000 c=%0d got=%h exp=%h", c, {AN, SEG, DP}, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_enable_dp();
        logic [11:0] e;
        blank_lz = 1'b0;
        value    = 16'h8421;
        digit_en = 4'b0101;
        dp_in    = 4'b0011;
        waitTick("en");
        for (int c = 0; c < FRAME; c++) begin
            e = frameExp(c, 16'hFBFE, {7'h7F, 7'b0011001, 7'h7F, 7'b1111001}, 4'b1110);
            checks++;
            if ({AN, SEG, DP} !== e) begin
                failures++;
                $display("[TB] FAIL en_dp c=%0d got=%h exp=%h", c, {AN, SEG, DP}, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] e;
        repeat (20) @(negedge clk);
        checks++;
        if ({AN, SEG} !== {4'b1011, 7'b0011001}) begin
            failures++;
            $display("[TB] FAIL areset_pre got=%h_%h exp=b_19", AN, SEG);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({AN, SEG, DP, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL areset_now got=%h_%h_%b_%b exp=f_7f_1_0", AN, SEG, DP, frame_tick);
        end
        repeat (2) @(negedge clk);
        value    = 16'hBEEF;
        digit_en = 4'hF;
        dp_in    = 4'h0;
        rst      = 1'b0;
        @(negedge clk);
        for (int c = 0; c < FRAME; c++) begin
            e = frameExp(c, 16'h7BDE, {7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110}, 4'hF);
            checks++;
            if ({AN, SEG, DP} !== e) begin
                failures++;
                $display("[TB] FAIL areset_frame c=%0d got=%h exp=%h", c, {AN, SEG, DP}, e);
            end
            checks++;
            if (frame_tick !== 1'(c == 0)) begin
                failures++;
                $display("[TB] FAIL areset_tick c=%0d got=%b exp=%b", c, frame_tick, c == 0);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_leading_zero();
        test_enable_dp();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
